// File: rtl/avmm_pio_gen2_if.sv
// Avalon-MM slave bundle for avmm_pio_gen2.
// Handshake: there is no waitrequest. A read or write strobe is accepted on every rising edge
// where it is high. Read data appears on avs_readdata one cycle after the read strobe and is 0 otherwise.
interface avmm_pio_gen2_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/avmm_pio_gen2.sv
// Parametrised Avalon-MM PIO: synchronised and debounced inputs, edge capture, maskable level IRQ,
// and set/clear output register. Optional hardware blink is built when PIO_BLINK_EN is defined.
module avmm_pio_gen2 #(
  parameter int              IN_W         = 10,
  parameter int              OUT_W        = 10,
  parameter int              DEBOUNCE_CYC = 50000,
  parameter int              EDGE_MODE    = 0,
  parameter logic [OUT_W-1:0] OUT_RESET   = '0,
  parameter int              BLINK_DIV    = 25000000
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  avmm_pio_gen2_if.slave   avs,
  output logic             irq,
  input  logic [IN_W-1:0]  pio_in_export,
  output logic [OUT_W-1:0] pio_out_export
);

  localparam logic [2:0] A_IN_DATA  = 3'd0;
  localparam logic [2:0] A_OUT_DATA = 3'd1;
  localparam logic [2:0] A_OUT_SET  = 3'd2;
  localparam logic [2:0] A_OUT_CLR  = 3'd3;
  localparam logic [2:0] A_IRQ_MASK = 3'd4;
  localparam logic [2:0] A_EDGE_CAP = 3'd5;
  localparam logic [2:0] A_STATUS   = 3'd6;
  localparam logic [2:0] A_BLINK    = 3'd7;

  logic [IN_W-1:0]  sync1;
  logic [IN_W-1:0]  sync2;
  logic [IN_W-1:0]  db;
  logic [IN_W-1:0]  db_nxt;
  logic [IN_W-1:0]  edge_hit;
  logic [IN_W-1:0]  edge_cap;
  logic [IN_W-1:0]  irq_mask;
  logic [IN_W-1:0]  w1c_bits;
  logic [OUT_W-1:0] out_data;
  logic [IN_W-1:0]  wd_in;
  logic [OUT_W-1:0] wd_out;
  logic [31:0]      rd_mux;
  logic [31:0]      blink_rd;
  logic             blink_present;

  logic wr_out;
  logic wr_set;
  logic wr_clr;
  logic wr_mask;
  logic wr_cap;

  assign wd_in   = avs.avs_writedata[IN_W-1:0];
  assign wd_out  = avs.avs_writedata[OUT_W-1:0];
  assign wr_out  = avs.avs_write && (avs.avs_address == A_OUT_DATA);
  assign wr_set  = avs.avs_write && (avs.avs_address == A_OUT_SET);
  assign wr_clr  = avs.avs_write && (avs.avs_address == A_OUT_CLR);
  assign wr_mask = avs.avs_write && (avs.avs_address == A_IRQ_MASK);
  assign wr_cap  = avs.avs_write && (avs.avs_address == A_EDGE_CAP);

  // Upper write-data bits beyond the channel widths are intentionally dropped.
  logic unused_wdata;
  assign unused_wdata = ^avs.avs_writedata;

  // Two-flop synchroniser for the asynchronous pins.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pio_in_export;
      sync2 <= sync1;
    end
  end

  generate
    if (DEBOUNCE_CYC == 0) begin : g_db_bypass
      assign db_nxt = sync2;
    end else begin : g_db
      localparam int              CW       = $clog2(DEBOUNCE_CYC + 1);
      localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYC - 1);
      for (genvar i = 0; i < IN_W; i++) begin : g_bit
        logic [CW-1:0] cnt;
        // Accept the new level only after it has disagreed with db for DEBOUNCE_CYC cycles.
        assign db_nxt[i] = ((sync2[i] != db[i]) && (cnt == CNT_LAST)) ? sync2[i] : db[i];
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
          if (!reset_reset_n) begin
            cnt <= '0;
          end else if ((sync2[i] == db[i]) || (cnt == CNT_LAST)) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    edge_hit = '0;
    if (EDGE_MODE == 0)      edge_hit = db_nxt & ~db;
    else if (EDGE_MODE == 1) edge_hit = ~db_nxt & db;
    else                     edge_hit = db_nxt ^ db;
  end

  assign w1c_bits = wr_cap ? wd_in : '0;

  // A new edge on the same cycle as its W1C leaves the bit set.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      db       <= '0;
      edge_cap <= '0;
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      db       <= db_nxt;
      edge_cap <= (edge_cap & ~w1c_bits) | edge_hit;
      if (wr_mask) irq_mask <= wd_in;
      irq      <= |(edge_cap & irq_mask);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      out_data <= OUT_RESET;
    end else if (wr_out) begin
      out_data <= wd_out;
    end else if (wr_set) begin
      out_data <= out_data | wd_out;
    end else if (wr_clr) begin
      out_data <= out_data & ~wd_out;
    end
  end

`ifdef PIO_BLINK_EN
  localparam int            PW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(BLINK_DIV - 1);

  logic [PW-1:0]    prescale;
  logic             blink_phase;
  logic [OUT_W-1:0] blink_mask;

  // Free-running prescaler; phase flips once every BLINK_DIV cycles.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      prescale    <= '0;
      blink_phase <= 1'b0;
      blink_mask  <= '0;
    end else begin
      if (prescale == PRE_LAST) begin
        prescale    <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        prescale <= prescale + 1'b1;
      end
      if (avs.avs_write && (avs.avs_address == A_BLINK)) blink_mask <= wd_out;
    end
  end

  assign pio_out_export = out_data ^ (blink_mask & out_data & {OUT_W{blink_phase}});
  assign blink_present  = 1'b1;
  assign blink_rd       = 32'(blink_mask);
`else
  assign pio_out_export = out_data;
  assign blink_present  = 1'b0;
  assign blink_rd       = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (avs.avs_address)
      A_IN_DATA:  rd_mux = 32'(db);
      A_OUT_DATA: rd_mux = 32'(out_data);
      A_OUT_SET:  rd_mux = '0;
      A_OUT_CLR:  rd_mux = '0;
      A_IRQ_MASK: rd_mux = 32'(irq_mask);
      A_EDGE_CAP: rd_mux = 32'(edge_cap);
      A_STATUS:   rd_mux = {30'b0, blink_present, irq};
      A_BLINK:    rd_mux = blink_rd;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs.avs_readdata <= '0;
    end else begin
      avs.avs_readdata <= avs.avs_read ? rd_mux : 32'd0;
    end
  end

endmodule

// File: tb/tb_avmm_pio_gen2.sv
// Self-checking bench for avmm_pio_gen2: directed scenarios plus random bus/pin traffic against a
// cycle-stepped reference model built from a pin-history window (PIO_BLINK_EN optional).
module tb_avmm_pio_gen2;
  localparam int IN_W      = 10;
  localparam int OUT_W     = 10;
  localparam int DC        = 4;
  localparam int EDGE_MODE = 0;
  localparam int BLINK_DIV = 8;
  localparam logic [OUT_W-1:0] OUT_RESET = '0;
`ifdef PIO_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             irq;
  logic [IN_W-1:0]  pin;
  logic [OUT_W-1:0] pout;

  avmm_pio_gen2_if bus();

  avmm_pio_gen2 #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DEBOUNCE_CYC(DC), .EDGE_MODE(EDGE_MODE),
    .OUT_RESET(OUT_RESET), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .avs(bus),
    .irq(irq),
    .pio_in_export(pin),
    .pio_out_export(pout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0]      exp_q[$];
  logic [IN_W-1:0]  pin_hist[$];
  logic [IN_W-1:0]  m_db, m_edge, m_mask;
  logic [OUT_W-1:0] m_out, m_blink;
  logic             m_irq;
  int               m_cycles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_db = '0; m_edge = '0; m_mask = '0; m_blink = '0; m_irq = 1'b0;
    m_out = OUT_RESET; m_cycles = 0;
    pin_hist = {};
    for (int i = 0; i < DC + 2; i++) pin_hist.push_back('0);
  endtask

  function automatic logic [OUT_W-1:0] exp_out();
    logic phase;
    phase = BLINK_ON && (((m_cycles / BLINK_DIV) % 2) == 1);
    return m_out ^ (m_blink & m_out & {OUT_W{phase}});
  endfunction

  function automatic logic [31:0] reg_value(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_db);
      3'd1: return 32'(m_out);
      3'd4: return 32'(m_mask);
      3'd5: return 32'(m_edge);
      3'd6: return {30'b0, BLINK_ON, m_irq};
      3'd7: return 32'(m_blink);
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the spec behaviour; a level is accepted once the last DC synchronised
  // samples all agree and differ from the current debounced value.
  task automatic model_step();
    logic [IN_W-1:0] nd, ev, w1c;
    logic [31:0]     wd;
    int              sz;
    if (!rst_n) begin
      model_reset();
      exp_q.push_back(32'd0);
      return;
    end
    exp_q.push_back(bus.avs_read ? reg_value(bus.avs_address) : 32'd0);
    wd = bus.avs_writedata;
    sz = pin_hist.size();
    nd = m_db;
    for (int b = 0; b < IN_W; b++) begin
      logic v;
      bit   stable;
      v = pin_hist[sz-2][b];
      stable = 1'b1;
      for (int j = 0; j < DC; j++) if (pin_hist[sz-2-j][b] != v) stable = 1'b0;
      if (stable && (v != m_db[b])) nd[b] = v;
    end
    pin_hist.push_back(pin);
    void'(pin_hist.pop_front());
    if (EDGE_MODE == 0)      ev = nd & ~m_db;
    else if (EDGE_MODE == 1) ev = ~nd & m_db;
    else                     ev = nd ^ m_db;
    m_irq = |(m_edge & m_mask);
    w1c = (bus.avs_write && bus.avs_address == 3'd5) ? wd[IN_W-1:0] : '0;
    m_edge = (m_edge & ~w1c) | ev;
    m_db = nd;
    if (bus.avs_write) begin
      case (bus.avs_address)
        3'd1: m_out = wd[OUT_W-1:0];
        3'd2: m_out = m_out | wd[OUT_W-1:0];
        3'd3: m_out = m_out & ~wd[OUT_W-1:0];
        3'd4: m_mask = wd[IN_W-1:0];
        3'd7: if (BLINK_ON) m_blink = wd[OUT_W-1:0];
        default: ;
      endcase
    end
    m_cycles++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    e = exp_q.pop_front();
    check("readdata", bus.avs_readdata, e);
    check("irq", {31'b0, irq}, {31'b0, m_irq});
    check("pio_out", 32'(pout), 32'(exp_out()));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.avs_write = 1'b1; bus.avs_address = a; bus.avs_writedata = d;
    tick();
    bus.avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus.avs_read = 1'b1; bus.avs_address = a;
    tick();
    bus.avs_read = 1'b0;
    d = bus.avs_readdata;
  endtask

  // Reads IN_DATA every cycle and returns the first cycle number it shows want (0 = never).
  task automatic wait_in(input logic [IN_W-1:0] want, output int first);
    first = 0;
    bus.avs_read = 1'b1; bus.avs_address = 3'd0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (first == 0 && bus.avs_readdata[IN_W-1:0] == want) first = t;
    end
    bus.avs_read = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    int first;
    int toggles;
    logic prev;
    pin = '0;
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    bus.avs_address = '0; bus.avs_writedata = '0;
    model_reset();

    ticks(3);
    bus_read(3'd0, d);
    check("rst_in_data", d, 32'd0);
    check("rst_out", 32'(pout), 32'(OUT_RESET));
    check("rst_irq", {31'b0, irq}, 32'd0);
    rst_n = 1'b1;
    ticks(2);

    // Glitch shorter than DC cycles is rejected.
    pin[3] = 1'b1; ticks(3); pin[3] = 1'b0; ticks(8);
    bus_read(3'd0, d); check("glitch_in", d, 32'd0);
    bus_read(3'd5, d); check("glitch_cap", d, 32'd0);

    // Held input: db changes 2+DC edges after the pin, the read shows it one edge later.
    pin[3] = 1'b1;
    wait_in(10'h008, first);
    check("db_latency", first, 2 + DC + 1);
    bus_read(3'd5, d); check("edge_cap", d, 32'h008);

    // Output register write / set / clear.
    bus_write(3'd1, 32'h0F0); check("out_data", 32'(pout), 32'h0F0);
    bus_write(3'd2, 32'h003); check("out_set", 32'(pout), 32'h0F3);
    bus_write(3'd3, 32'h010); check("out_clr", 32'(pout), 32'h0E3);
    bus_read(3'd2, d); check("set_reads0", d, 32'd0);

    // IRQ on rising edge of bit3.
    bus_write(3'd5, 32'h3FF);
    bus_write(3'd4, 32'h008);
    pin[3] = 1'b0; ticks(10);
    pin[3] = 1'b1;
    first = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (first == 0 && irq) first = t;
    end
    check("irq_latency", first, 2 + DC + 1);
    bus_write(3'd5, 32'h008);
    check("irq_hold", {31'b0, irq}, 32'd1);
    tick();
    check("irq_clear", {31'b0, irq}, 32'd0);
    // W1C on the same edge as a new rising edge: set wins.
    pin[3] = 1'b0; ticks(10);
    pin[3] = 1'b1; ticks(2 + DC - 1);
    bus_write(3'd5, 32'h008);
    bus_read(3'd5, d); check("w1c_collide_cap", d, 32'h008);
    check("w1c_collide_irq", {31'b0, irq}, 32'd1);
    bus_read(3'd6, d); check("status", d, {30'b0, BLINK_ON, 1'b1});

    // Reset pulse mid-debounce with bit0 held high.
    pin = '0; ticks(10);
    pin[0] = 1'b1; ticks(2);
    rst_n = 1'b0; ticks(2);
    bus_read(3'd0, d); check("rst_mid_in", d, 32'd0);
    rst_n = 1'b1;
    wait_in(10'h001, first);
    check("rst_mid_latency", first, 2 + DC + 1);
    bus_read(3'd5, d); check("rst_mid_cap", d, 32'h001);

    // Blink on bit0 (or steady when the feature is not built).
    bus_write(3'd1, 32'h001);
    bus_write(3'd7, 32'h001);
    bus_read(3'd7, d); check("blink_reg", d, BLINK_ON ? 32'h001 : 32'h000);
    toggles = 0; prev = pout[0];
    for (int t = 0; t < 4 * BLINK_DIV; t++) begin
      tick();
      if (pout[0] != prev) toggles++;
      prev = pout[0];
    end
    check("blink_toggles", toggles, BLINK_ON ? 4 : 0);

    // Random bus and pin traffic against the model.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        int k;
        k = $urandom_range(0, IN_W - 1);
        pin[k] = ~pin[k];
      end
      case ($urandom_range(0, 3))
        1: bus_read(3'($urandom_range(0, 7)), d);
        2: bus_write(3'($urandom_range(0, 7)), $urandom);
        default: tick();
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
